// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and latency defaults for the hazard controller
package hazard_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_t;

   typedef logic [5:0] count_t;

   localparam int DEF_MULT_CYCLES = 4;
   localparam int DEF_DIV_CYCLES  = 32;

endpackage

// File: rtl/mdu_timer.sv
// rtl/mdu_timer.sv - MDU latency counter with zero detect and registered done pulse
module mdu_timer
   import hazard_pkg::*;
(
   input  logic   clock,
   input  logic   reset,
   input  logic   load,
   input  count_t loadValue,
   input  logic   busy,
   output count_t count,
   output logic   zero,
   output logic   done
);

   assign zero = (count == count_t'(0));

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= count_t'(0);
         done  <= 1'b0;
      end else begin
         done <= busy & zero;
         if (load)
            count <= loadValue;
         else if (busy && !zero)
            count <= count - count_t'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush control for load-use and multiply/divide hazards
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       MemReadE,
   input  logic [4:0] RAddrE,
   input  logic [4:0] RsAddrD,
   input  logic [4:0] RtAddrD,
   input  logic       UsesRsD,
   input  logic       UsesRtD,
   input  logic       BranchTakenE,
   input  logic       MDUStartE,
   input  logic       MDUOpE,
   input  logic       MDUReadD,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE,
   output logic       MDUBusy,
   output logic       MDUDone,
   output logic [5:0] MDUCount
);

   mdu_state_t state, stateNext;
   count_t     count, loadValue;
   logic       countZero, startAccept, loadUse, mduStall, holdPipe;

   // Only an idle unit accepts a start; a start while busy is ignored.
   assign startAccept = (state == IDLE) & MDUStartE;
   assign loadValue   = MDUOpE ? count_t'(DIV_CYCLES - 1) : count_t'(MULT_CYCLES - 1);

   mdu_timer uTimer (
      .clock     (Clock),
      .reset     (Reset),
      .load      (startAccept),
      .loadValue (loadValue),
      .busy      (state == BUSY),
      .count     (count),
      .zero      (countZero),
      .done      (MDUDone)
   );

   always_ff @(posedge Clock) begin
      if (Reset)
         state <= IDLE;
      else
         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (MDUStartE) stateNext = BUSY;
         BUSY: if (countZero) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign loadUse  = MemReadE & (RAddrE != 5'd0) &
                     ((UsesRsD & (RsAddrD == RAddrE)) | (UsesRtD & (RtAddrD == RAddrE)));
   assign mduStall = (state == BUSY) & MDUReadD;
   assign holdPipe = loadUse | mduStall;

   // A taken branch squashes the younger instructions, so any hold on them is moot.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      if (!Reset) begin
         if (BranchTakenE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (holdPipe) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   assign MDUBusy  = (state == BUSY);
   assign MDUCount = count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

   logic       Clock;
   logic       Reset;
   logic       MemReadE;
   logic [4:0] RAddrE;
   logic [4:0] RsAddrD;
   logic [4:0] RtAddrD;
   logic       UsesRsD;
   logic       UsesRtD;
   logic       BranchTakenE;
   logic       MDUStartE;
   logic       MDUOpE;
   logic       MDUReadD;
   logic       StallF;
   logic       StallD;
   logic       FlushD;
   logic       FlushE;
   logic       MDUBusy;
   logic       MDUDone;
   logic [5:0] MDUCount;

   int errors = 0;
   int checks = 0;

   hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .MemReadE     (MemReadE),
      .RAddrE       (RAddrE),
      .RsAddrD      (RsAddrD),
      .RtAddrD      (RtAddrD),
      .UsesRsD      (UsesRsD),
      .UsesRtD      (UsesRtD),
      .BranchTakenE (BranchTakenE),
      .MDUStartE    (MDUStartE),
      .MDUOpE       (MDUOpE),
      .MDUReadD     (MDUReadD),
      .StallF       (StallF),
      .StallD       (StallD),
      .FlushD       (FlushD),
      .FlushE       (FlushE),
      .MDUBusy      (MDUBusy),
      .MDUDone      (MDUDone),
      .MDUCount     (MDUCount)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit past the next rising edge, where inputs are driven.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic chkStall(input string tag, input logic s, input logic fd, input logic fe);
      chk1({tag, ".StallF"}, StallF, s);
      chk1({tag, ".StallD"}, StallD, s);
      chk1({tag, ".FlushD"}, FlushD, fd);
      chk1({tag, ".FlushE"}, FlushE, fe);
   endtask

   task automatic idleInputs();
      MemReadE = 0; RAddrE = 0; RsAddrD = 0; RtAddrD = 0;
      UsesRsD = 0; UsesRtD = 0; BranchTakenE = 0;
      MDUStartE = 0; MDUOpE = 0; MDUReadD = 0;
   endtask

   logic sawDone;

   initial begin
      idleInputs();
      Reset = 1;
      // Hazardous inputs under reset must still produce no stall or flush.
      MemReadE = 1; RAddrE = 5; RsAddrD = 5; UsesRsD = 1; BranchTakenE = 1; MDUReadD = 1;
      tick(); settle();
      chkStall("reset", 0, 0, 0);
      chk1("reset.MDUBusy", MDUBusy, 0);
      chk1("reset.MDUDone", MDUDone, 0);
      chk6("reset.MDUCount", MDUCount, 6'd0);

      // Load-use on Rs: one-cycle stall, then the load has moved to MEM.
      tick(); Reset = 0; idleInputs();
      MemReadE = 1; RAddrE = 5; RsAddrD = 5; UsesRsD = 1;
      settle();
      chkStall("loaduse_rs", 1, 0, 1);
      tick(); MemReadE = 0; settle();
      chkStall("loaduse_after", 0, 0, 0);

      // Register 0 never creates a hazard.
      tick(); MemReadE = 1; RAddrE = 0; RsAddrD = 0; UsesRsD = 1; settle();
      chkStall("loaduse_r0", 0, 0, 0);

      // Rt match only counts when Rt is actually read.
      tick(); idleInputs(); MemReadE = 1; RAddrE = 7; RsAddrD = 3; RtAddrD = 7; UsesRsD = 1; settle();
      chkStall("loaduse_rt_unused", 0, 0, 0);
      tick(); UsesRtD = 1; settle();
      chkStall("loaduse_rt", 1, 0, 1);

      // Multiply with a dependent HI/LO reader waiting in ID.
      tick(); idleInputs(); MDUStartE = 1; MDUOpE = 0; MDUReadD = 1; settle();
      chkStall("mul.c0", 0, 0, 0);
      chk1("mul.c0.MDUBusy", MDUBusy, 0);
      for (int c = 1; c <= 4; c++) begin
         tick(); MDUStartE = 0; settle();
         chk6($sformatf("mul.c%0d.MDUCount", c), MDUCount, 6'(4 - c));
         chk1($sformatf("mul.c%0d.MDUBusy", c), MDUBusy, 1);
         chk1($sformatf("mul.c%0d.MDUDone", c), MDUDone, 0);
         chkStall($sformatf("mul.c%0d", c), 1, 0, 1);
      end
      tick(); settle();
      chk1("mul.c5.MDUDone", MDUDone, 1);
      chk1("mul.c5.MDUBusy", MDUBusy, 0);
      chk6("mul.c5.MDUCount", MDUCount, 6'd0);
      chkStall("mul.c5", 0, 0, 0);
      tick(); MDUReadD = 0; settle();
      chk1("mul.c6.MDUDone", MDUDone, 0);

      // Divide, no reader; a stray start mid-operation must be ignored.
      tick(); idleInputs(); MDUStartE = 1; MDUOpE = 1; settle();
      for (int c = 1; c <= 32; c++) begin
         tick(); MDUStartE = (c == 10); MDUOpE = 0; settle();
         chk6($sformatf("div.c%0d.MDUCount", c), MDUCount, 6'(32 - c));
         chk1($sformatf("div.c%0d.MDUBusy", c), MDUBusy, 1);
         chk1($sformatf("div.c%0d.MDUDone", c), MDUDone, 0);
         chk1($sformatf("div.c%0d.StallF", c), StallF, 0);
      end
      tick(); MDUStartE = 0; settle();
      chk1("div.c33.MDUDone", MDUDone, 1);
      chk1("div.c33.MDUBusy", MDUBusy, 0);

      // Start accepted alongside a taken branch; branch later overrides an MDU stall.
      tick(); idleInputs(); MDUStartE = 1; BranchTakenE = 1; settle();
      chkStall("br.c0", 0, 1, 1);
      tick(); MDUStartE = 0; BranchTakenE = 0; MDUReadD = 1; settle();
      chk6("br.c1.MDUCount", MDUCount, 6'd3);
      chkStall("br.c1", 1, 0, 1);
      tick(); BranchTakenE = 1; settle();
      chk6("br.c2.MDUCount", MDUCount, 6'd2);
      chkStall("br.c2", 0, 1, 1);
      tick(); MemReadE = 1; RAddrE = 9; RsAddrD = 9; UsesRsD = 1; settle();
      chk6("br.c3.MDUCount", MDUCount, 6'd1);
      chkStall("br.c3", 0, 1, 1);
      tick(); idleInputs(); settle();
      chk6("br.c4.MDUCount", MDUCount, 6'd0);
      tick(); settle();
      chk1("br.c5.MDUDone", MDUDone, 1);

      // Reset abandons a divide at count 17; no done pulse may follow.
      tick(); idleInputs(); MDUStartE = 1; MDUOpE = 1; settle();
      for (int c = 1; c <= 15; c++) begin
         tick(); MDUStartE = 0; settle();
      end
      chk6("rst.c15.MDUCount", MDUCount, 6'd17);
      Reset = 1; MDUReadD = 1; settle();
      chkStall("rst.c15", 0, 0, 0);
      tick(); Reset = 0; settle();
      chk1("rst.c16.MDUBusy", MDUBusy, 0);
      chk6("rst.c16.MDUCount", MDUCount, 6'd0);
      chk1("rst.c16.MDUDone", MDUDone, 0);
      chkStall("rst.c16", 0, 0, 0);
      sawDone = 0;
      for (int c = 17; c <= 40; c++) begin
         tick(); settle();
         sawDone = sawDone | MDUDone | MDUBusy;
      end
      chk1("rst.no_done", sawDone, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
